// File: rtl/keypad_debouncer_if.sv
// Signal bundle between the keypad column scanner and the key debouncer.
// The debouncer is the master: it owns scan-enable and the decoded key outputs.
interface keypad_debouncer_if;
  logic [3:0] row_stable;
  logic [3:0] col_stable;
  logic       enable_scan;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  row_stable,
    input  col_stable,
    output enable_scan,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output row_stable,
    output col_stable,
    input  enable_scan,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_debouncer.sv
// Locks onto one pressed key from the scanner's aligned row/column samples,
// debounces press and release, and reports the key as a hex code.
module keypad_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
  input  logic               clk,
  input  logic               reset,
  keypad_debouncer_if.master kp
);
  localparam int unsigned      CNT_W      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0]       FLUSH_LAST = 2'd2;

  typedef enum logic [1:0] {
    ST_FLUSH,
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD
  } state_e;

  state_e           state_q;
  logic [1:0]       flush_cnt_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [3:0]       cap_row_q;
  logic [3:0]       cap_col_q;
  logic             enable_scan_q;
  logic [3:0]       key_code_q;
  logic [3:0]       key_code_d;
  logic             key_valid_q;
  logic             key_held_q;

  logic sample_valid;
  logic on_cap_col;
  logic cap_row_hit;

  function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
    return {oh[3] | oh[2], oh[3] | oh[1]};
  endfunction

  // Index is {row, col}; row 3 carries E,0,F,D.
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = 4'h0;
    case ({row, col})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      4'hF: code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  // Ghosting and idle samples fail the one-hot test and are never captured.
  assign sample_valid = $onehot(kp.row_stable) && $onehot(kp.col_stable);
  assign on_cap_col   = (kp.col_stable == cap_col_q);
  assign cap_row_hit  = |(kp.row_stable & cap_row_q);
  assign cnt_d        = cnt_q + CNT_W'(1);
  assign key_code_d   = key_map(onehot_to_idx(cap_row_q), onehot_to_idx(cap_col_q));

  // NOTE: every register below uses <= so all branches see the pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_FLUSH;
      flush_cnt_q   <= '0;
      cnt_q         <= '0;
      cap_row_q     <= '0;
      cap_col_q     <= '0;
      enable_scan_q <= 1'b0;
      key_code_q    <= '0;
      key_valid_q   <= 1'b0;
      key_held_q    <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      unique case (state_q)
        ST_FLUSH: begin
          if (flush_cnt_q == FLUSH_LAST) begin
            state_q       <= ST_SCAN;
            enable_scan_q <= 1'b1;
          end else begin
            flush_cnt_q <= flush_cnt_q + 2'd1;
          end
        end

        ST_SCAN: begin
          if (sample_valid) begin
            cap_row_q <= kp.row_stable;
            cap_col_q <= kp.col_stable;
            cnt_q     <= '0;
            state_q   <= ST_DEBOUNCE;
          end
        end

        ST_DEBOUNCE: begin
          // A missing captured row wins even on the terminal count.
          if (on_cap_col && !cap_row_hit) begin
            state_q       <= ST_FLUSH;
            flush_cnt_q   <= '0;
            enable_scan_q <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            state_q     <= ST_HELD;
            cnt_q       <= '0;
            key_code_q  <= key_code_d;
            key_valid_q <= 1'b1;
            key_held_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        ST_HELD: begin
          if (on_cap_col && cap_row_hit) begin
            cnt_q <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q       <= ST_FLUSH;
            flush_cnt_q   <= '0;
            enable_scan_q <= 1'b0;
            key_held_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        default: begin
          state_q       <= ST_FLUSH;
          flush_cnt_q   <= '0;
          enable_scan_q <= 1'b0;
        end
      endcase
    end
  end

  assign kp.enable_scan = enable_scan_q;
  assign kp.key_code    = key_code_q;
  assign kp.key_valid   = key_valid_q;
  assign kp.key_held    = key_held_q;
endmodule
